dyn_partition_state_gen: RTL and testbench

// - Sequential generator for the dual-counter / twisted-mode transition system that the
//   dyn-partition fixpoint checker evaluates. It sits directly upstream of that checker.
// - From a seed state it walks the transition relation one step per accepted transfer.
// - Each transfer emits a (current, next) state pair on a valid/ready stream.
// - It stops when the walk returns to the seed (cycle found) or a step budget is exhausted.

---
 rtl/dyn_partition_state_gen.sv | 130 +++++++++++++
 tb/tb_dyn_partition_state_gen.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dyn_partition_state_gen.sv
// rtl/dyn_partition_state_gen.sv - walks the dual-counter / twisted-mode transition system from a seed
// Emits (current, next) state pairs on a valid/ready stream until the walk returns to the seed or the budget runs out.
module dyn_partition_state_gen #(
  parameter int CW        = 3,
  parameter int MAX_STEPS = 64,
  localparam int SW       = 2*CW+2,
  localparam int PW       = $clog2(MAX_STEPS+1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  input  logic          load_en,
  input  logic [SW-1:0] load_state,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [SW-1:0] out_cur,
  output logic [SW-1:0] out_nxt,
  output logic          done,
  output logic          cycle_found,
  output logic [PW-1:0] period
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [SW-1:0] cur_q, cur_d;
  logic [SW-1:0] seed_q, seed_d;
  logic [PW-1:0] cnt_q, cnt_d;
  logic          done_q, done_d;
  logic          found_q, found_d;
  logic [PW-1:0] period_q, period_d;

  logic [CW-1:0] cnt_a, cnt_b;
  logic          m0, m1, sel;
  logic [SW-1:0] nxt;
  logic [PW-1:0] cnt_inc;
  logic [SW-1:0] seed_sel;

  assign cnt_a = cur_q[CW-1:0];
  assign cnt_b = cur_q[2*CW-1:CW];
  assign m0    = cur_q[2*CW];
  assign m1    = cur_q[2*CW+1];
  assign sel   = m0 ^ m1;

  // Mode bits form a 4-step Johnson sequence, so a and b take turns incrementing.
  always_comb begin
    nxt = {m0, ~m1,
           sel ? cnt_b + CW'(1) : cnt_b,
           sel ? cnt_a : cnt_a + CW'(1)};
  end

  assign cnt_inc  = cnt_q + PW'(1);
  assign seed_sel = load_en ? load_state : '0;

  always_comb begin
    state_d  = state_q;
    cur_d    = cur_q;
    seed_d   = seed_q;
    cnt_d    = cnt_q;
    done_d   = done_q;
    found_d  = found_q;
    period_d = period_q;
    if (abort) begin
      state_d = S_IDLE;
      done_d  = 1'b0;
      found_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            seed_d  = seed_sel;
            cur_d   = seed_sel;
            cnt_d   = '0;
            done_d  = 1'b0;
            found_d = 1'b0;
            state_d = S_RUN;
          end
        end
        S_RUN: begin
          if (out_ready) begin
            cur_d = nxt;
            cnt_d = cnt_inc;
            // Seed match takes priority over budget exhaustion on the same step.
            if (nxt == seed_q) begin
              state_d  = S_DONE;
              done_d   = 1'b1;
              found_d  = 1'b1;
              period_d = cnt_inc;
            end else if (cnt_inc == PW'(MAX_STEPS)) begin
              state_d  = S_DONE;
              done_d   = 1'b1;
              found_d  = 1'b0;
              period_d = cnt_inc;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cur_q    <= '0;
      seed_q   <= '0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      found_q  <= 1'b0;
      period_q <= '0;
    end else begin
      state_q  <= state_d;
      cur_q    <= cur_d;
      seed_q   <= seed_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
      found_q  <= found_d;
      period_q <= period_d;
    end
  end

  assign out_valid   = (state_q == S_RUN);
  assign out_cur     = cur_q;
  assign out_nxt     = nxt;
  assign done        = done_q;
  assign cycle_found = found_q;
  assign period      = period_q;

endmodule

// File: tb/tb_dyn_partition_state_gen.sv
// tb/tb_dyn_partition_state_gen.sv - directed bench for dyn_partition_state_gen
// A second instance with a 10-step budget shares the stimulus to exercise budget exhaustion.
module tb_dyn_partition_state_gen;

  localparam int SW  = 8;
  localparam int PW  = 7;
  localparam int PW10 = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          abort;
  logic          load_en;
  logic [SW-1:0] load_state;
  logic          out_ready;

  logic          out_valid, done, cycle_found;
  logic [SW-1:0] out_cur, out_nxt;
  logic [PW-1:0] period;

  logic          v10, done10, found10;
  logic [SW-1:0] cur10, nxt10;
  logic [PW10-1:0] period10;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dyn_partition_state_gen #(.CW(3), .MAX_STEPS(64)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .load_en(load_en),
    .load_state(load_state), .out_valid(out_valid), .out_ready(out_ready),
    .out_cur(out_cur), .out_nxt(out_nxt), .done(done), .cycle_found(cycle_found),
    .period(period)
  );

  dyn_partition_state_gen #(.CW(3), .MAX_STEPS(10)) dut10 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .load_en(load_en),
    .load_state(load_state), .out_valid(v10), .out_ready(out_ready),
    .out_cur(cur10), .out_nxt(nxt10), .done(done10), .cycle_found(found10),
    .period(period10)
  );

  function automatic logic [7:0] f_model(input logic [7:0] s);
    logic [2:0] a;
    logic [2:0] b;
    a = s[2:0];
    b = s[5:3];
    if (s[6] ^ s[7]) b = b + 3'd1;
    else             a = a + 3'd1;
    return {s[6], ~s[7], b, a};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input logic le, input logic [SW-1:0] ls);
    start = 1'b1; load_en = le; load_state = ls;
    tick();
    start = 1'b0; load_en = 1'b0; load_state = '0;
  endtask

  task automatic run_to_done(output int xfers);
    int budget;
    xfers = 0;
    budget = 0;
    while (!done && budget < 100) begin
      if (out_valid && out_ready) xfers++;
      tick();
      budget++;
    end
    n_checks++;
    if (!done) begin
      n_fail++;
      $display("FAIL run_timeout done=%0b required 1", done);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    n_checks++;
    if ({out_valid, done, cycle_found} !== 3'b000 || out_cur !== 8'h00 || period !== 7'd0) begin
      n_fail++;
      $display("FAIL reset valid=%0b done=%0b found=%0b cur=%h period=%0d required 0,0,0,00,0",
               out_valid, done, cycle_found, out_cur, period);
    end
    rst_n = 1'b1;
    tick();
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle valid=%0b required 0", out_valid);
    end
  endtask

  task automatic test_walk_seed0();
    logic [7:0] exp_tab [5];
    logic [7:0] exp;
    exp_tab[0] = 8'h00; exp_tab[1] = 8'h41; exp_tab[2] = 8'hC9;
    exp_tab[3] = 8'h8A; exp_tab[4] = 8'h12;
    out_ready = 1'b1;
    start_run(1'b0, 8'h00);
    exp = 8'h00;
    for (int k = 0; k < 16; k++) begin
      if (k < 5) begin
        n_checks++;
        if (out_cur !== exp_tab[k]) begin
          n_fail++;
          $display("FAIL walk_table step=%0d cur=%h required %h", k, out_cur, exp_tab[k]);
        end
      end
      n_checks++;
      if (out_valid !== 1'b1 || out_cur !== exp || out_nxt !== f_model(exp)) begin
        n_fail++;
        $display("FAIL walk step=%0d valid=%0b cur=%h nxt=%h required 1,%h,%h",
                 k, out_valid, out_cur, out_nxt, exp, f_model(exp));
      end
      tick();
      exp = f_model(exp);
    end
    n_checks++;
    if (done !== 1'b1 || cycle_found !== 1'b1 || period !== 7'd16 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL walk_done done=%0b found=%0b period=%0d valid=%0b required 1,1,16,0",
               done, cycle_found, period, out_valid);
    end
    n_checks++;
    if (done10 !== 1'b1 || found10 !== 1'b0 || period10 !== 4'd10 || v10 !== 1'b0 || cur10 !== 8'hED) begin
      n_fail++;
      $display("FAIL budget_done done=%0b found=%0b period=%0d valid=%0b cur=%h required 1,0,10,0,ed",
               done10, found10, period10, v10, cur10);
    end
  endtask

  task automatic test_backpressure();
    int xfers;
    out_ready = 1'b0;
    start_run(1'b0, 8'h00);
    for (int k = 0; k < 5; k++) begin
      n_checks++;
      if (out_valid !== 1'b1 || out_cur !== 8'h00 || out_nxt !== 8'h41 || done !== 1'b0) begin
        n_fail++;
        $display("FAIL backpressure_hold cyc=%0d valid=%0b cur=%h nxt=%h done=%0b required 1,00,41,0",
                 k, out_valid, out_cur, out_nxt, done);
      end
      tick();
    end
    out_ready = 1'b1;
    run_to_done(xfers);
    n_checks++;
    if (xfers != 16 || period !== 7'd16 || cycle_found !== 1'b1) begin
      n_fail++;
      $display("FAIL backpressure_done xfers=%0d period=%0d found=%0b required 16,16,1",
               xfers, period, cycle_found);
    end
  endtask

  task automatic test_load();
    int xfers;
    out_ready = 1'b0;
    start_run(1'b1, 8'h41);
    n_checks++;
    if (out_cur !== 8'h41 || out_nxt !== 8'hC9 || done !== 1'b0 || cycle_found !== 1'b0) begin
      n_fail++;
      $display("FAIL load_first cur=%h nxt=%h done=%0b found=%0b required 41,c9,0,0",
               out_cur, out_nxt, done, cycle_found);
    end
    out_ready = 1'b1;
    run_to_done(xfers);
    n_checks++;
    if (xfers != 16 || period !== 7'd16 || cycle_found !== 1'b1 || out_cur !== 8'h41) begin
      n_fail++;
      $display("FAIL load_done xfers=%0d period=%0d found=%0b cur=%h required 16,16,1,41",
               xfers, period, cycle_found, out_cur);
    end
  endtask

  task automatic test_abort();
    out_ready = 1'b1;
    start_run(1'b0, 8'h00);
    for (int k = 0; k < 5; k++) tick();
    n_checks++;
    if (out_cur !== 8'h53) begin
      n_fail++;
      $display("FAIL abort_pre cur=%h required 53", out_cur);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || done !== 1'b0 || cycle_found !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_idle valid=%0b done=%0b found=%0b required 0,0,0",
               out_valid, done, cycle_found);
    end
    start_run(1'b1, 8'hC9);
    n_checks++;
    if (out_valid !== 1'b1 || out_cur !== 8'hC9 || out_nxt !== 8'h8A) begin
      n_fail++;
      $display("FAIL abort_restart valid=%0b cur=%h nxt=%h required 1,c9,8a",
               out_valid, out_cur, out_nxt);
    end
    abort = 1'b1;
    tick();
    start = 1'b1; load_en = 1'b1; load_state = 8'h12;
    tick();
    start = 1'b0; abort = 1'b0; load_en = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL start_abort valid=%0b done=%0b required 0,0", out_valid, done);
    end
    tick();
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL start_abort_hold valid=%0b required 0", out_valid);
    end
  endtask

  task automatic test_run_start_and_reset();
    out_ready = 1'b1;
    start_run(1'b0, 8'h00);
    for (int k = 0; k < 3; k++) tick();
    start = 1'b1; load_en = 1'b1; load_state = 8'h41;
    tick();
    start = 1'b0; load_en = 1'b0;
    n_checks++;
    if (out_valid !== 1'b1 || out_cur !== 8'h12) begin
      n_fail++;
      $display("FAIL start_in_run valid=%0b cur=%h required 1,12", out_valid, out_cur);
    end
    rst_n = 1'b0;
    tick();
    n_checks++;
    if ({out_valid, done, cycle_found} !== 3'b000 || out_cur !== 8'h00 || period !== 7'd0 ||
        v10 !== 1'b0 || period10 !== 4'd0) begin
      n_fail++;
      $display("FAIL midrun_reset valid=%0b done=%0b found=%0b cur=%h period=%0d period10=%0d required 0,0,0,00,0,0",
               out_valid, done, cycle_found, out_cur, period, period10);
    end
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    rst_n = 1'b1; start = 1'b0; abort = 1'b0; load_en = 1'b0;
    load_state = '0; out_ready = 1'b0;
    #2;
    test_reset();
    test_walk_seed0();
    test_backpressure();
    test_load();
    test_abort();
    test_run_start_and_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
